// File: rtl/fir_out_decim_fifo_if.sv
// Bundle between the FIR output, the decimating FIFO and its consumer.
// The producer/consumer side drives through master; the FIFO block uses slave.
interface fir_out_decim_fifo_if #(
    parameter int word_size_out = 9,
    parameter int depth         = 8
);
    localparam int CNT_W = $clog2(depth) + 1;

    logic [word_size_out-1:0] Data_in;
    logic                     in_en;
    logic [word_size_out-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W-1:0]         count;
    logic                     overflow;

    modport master (
        output Data_in, in_en, out_ready,
        input  out_data, out_valid, count, overflow
    );

    modport slave (
        input  Data_in, in_en, out_ready,
        output out_data, out_valid, count, overflow
    );
endinterface

// File: rtl/fir_out_decim_fifo.sv
// Keeps one of every decim qualified FIR samples and buffers the kept samples
// in a first-word-fall-through FIFO with a sticky overflow flag.
module fir_out_decim_fifo #(
    parameter int word_size_out = 9,
    parameter int decim         = 4,
    parameter int depth         = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    fir_out_decim_fifo_if.slave  bus
);
    localparam int AW    = $clog2(depth);
    localparam int CW    = AW + 1;
    localparam int DCW   = (decim > 1) ? $clog2(decim) : 1;

    logic [word_size_out-1:0] mem_q [depth];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q,  count_d;
    logic [DCW-1:0]           dcnt_q,   dcnt_d;
    logic                     overflow_q, overflow_d;

    logic full, valid, pop, keep, push, drop;

    always_comb begin
        full  = (count_q == CW'(depth));
        valid = (count_q != '0);
        pop   = valid && bus.out_ready;
        keep  = bus.in_en && (dcnt_q == '0);
        // A full FIFO still accepts a kept sample when the head leaves this cycle.
        push  = keep && (!full || pop);
        drop  = keep && full && !pop;
    end

    always_comb begin
        dcnt_d = dcnt_q;
        if (bus.in_en) begin
            if (dcnt_q == DCW'(decim - 1)) begin
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + DCW'(1);
            end
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dcnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dcnt_q     <= dcnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; stale entries are never visible once count is 0.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= bus.Data_in;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? mem_q[rd_ptr_q] : '0;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fir_out_decim_fifo.sv
// Bench for fir_out_decim_fifo: three instances (decim 4, 1, 2) share stimulus
// and are checked against a queue-style model plus directed expectations.
module tb_fir_out_decim_fifo;
    localparam int DEC [3] = '{4, 1, 2};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] data_in = '0;
    logic       en = 1'b0;
    logic       rdy = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    fir_out_decim_fifo_if #(.word_size_out(9), .depth(8)) if0 ();
    fir_out_decim_fifo_if #(.word_size_out(9), .depth(8)) if1 ();
    fir_out_decim_fifo_if #(.word_size_out(9), .depth(8)) if2 ();

    assign if0.Data_in = data_in;  assign if0.in_en = en;  assign if0.out_ready = rdy;
    assign if1.Data_in = data_in;  assign if1.in_en = en;  assign if1.out_ready = rdy;
    assign if2.Data_in = data_in;  assign if2.in_en = en;  assign if2.out_ready = rdy;

    fir_out_decim_fifo #(.word_size_out(9), .decim(4), .depth(8)) dut0 (.clock(clock), .reset(reset), .bus(if0));
    fir_out_decim_fifo #(.word_size_out(9), .decim(1), .depth(8)) dut1 (.clock(clock), .reset(reset), .bus(if1));
    fir_out_decim_fifo #(.word_size_out(9), .decim(2), .depth(8)) dut2 (.clock(clock), .reset(reset), .bus(if2));

    logic [8:0] dout [3];
    logic       dval [3];
    logic [3:0] dcnt [3];
    logic       dovf [3];
    assign dout[0] = if0.out_data;  assign dval[0] = if0.out_valid;  assign dcnt[0] = if0.count;  assign dovf[0] = if0.overflow;
    assign dout[1] = if1.out_data;  assign dval[1] = if1.out_valid;  assign dcnt[1] = if1.count;  assign dovf[1] = if1.overflow;
    assign dout[2] = if2.out_data;  assign dval[2] = if2.out_valid;  assign dcnt[2] = if2.count;  assign dovf[2] = if2.overflow;

    // Reference model: unbounded head/tail indices into a large ring, a running
    // tally of qualified samples, and a sticky drop flag.
    logic [8:0] mmem [3][64];
    int         mhead [3];
    int         mtail [3];
    int         mnq [3];
    bit         movf [3];

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mhead[k] = 0; mtail[k] = 0; mnq[k] = 0; movf[k] = 1'b0;
            end else begin
                bit mpop, mkeep;
                mpop  = (mtail[k] - mhead[k] > 0) && rdy;
                mkeep = en && (mnq[k] % DEC[k] == 0);
                if (en) mnq[k]++;
                if (mkeep) begin
                    if ((mtail[k] - mhead[k] < 8) || mpop) begin
                        mmem[k][mtail[k] % 64] = data_in;
                        mtail[k]++;
                    end else begin
                        movf[k] = 1'b1;
                    end
                end
                if (mpop) mhead[k]++;
            end
        end
    endtask

    function automatic logic exp_valid(int k);
        return mtail[k] != mhead[k];
    endfunction

    function automatic logic [8:0] exp_data(int k);
        if (mtail[k] != mhead[k]) return mmem[k][mhead[k] % 64];
        return 9'd0;
    endfunction

    function automatic logic [3:0] exp_count(int k);
        return 4'(mtail[k] - mhead[k]);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; rdy = 1'b0; data_in = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dval[k] !== 1'b0 || dout[k] !== 9'd0 || dcnt[k] !== 4'd0 || dovf[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: valid/data/count/ovf got %b/%0d/%0d/%b want 0/0/0/0",
                         k, dval[k], dout[k], dcnt[k], dovf[k]);
            end
        end
    endtask

    task automatic test_basic_decim();
        logic [8:0] seen [3];
        int nseen = 0;
        int maxc = 0;
        logic       expv;
        logic [8:0] expd;
        do_reset();
        rdy = 1'b1; en = 1'b1;
        for (int d = 1; d <= 12; d++) begin
            data_in = 9'(d);
            tick();
            expv = (d % 4 == 1);
            expd = expv ? 9'(d) : 9'd0;
            n_cmp++;
            if (dval[0] !== expv || dout[0] !== expd) begin
                n_fail++;
                $display("FAIL basic_decim d=%0d: valid/data got %b/%0d want %b/%0d", d, dval[0], dout[0], expv, expd);
            end
            if (dval[0] === 1'b1 && nseen < 3) begin
                seen[nseen] = dout[0];
                nseen++;
            end
            if (int'(dcnt[0]) > maxc) maxc = int'(dcnt[0]);
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if (nseen != 3 || seen[0] !== 9'd1 || seen[1] !== 9'd5 || seen[2] !== 9'd9) begin
            n_fail++;
            $display("FAIL basic_decim seq: got n=%0d %0d,%0d,%0d want n=3 1,5,9", nseen, seen[0], seen[1], seen[2]);
        end
        n_cmp++;
        if (maxc > 1) begin
            n_fail++;
            $display("FAIL basic_decim maxcount: got %0d want <=1", maxc);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        rdy = 1'b0; en = 1'b1;
        for (int d = 1; d <= 33; d++) begin
            data_in = 9'(d);
            tick();
            if (d == 29) begin
                n_cmp++;
                if (dcnt[0] !== 4'd8 || dovf[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill@29: count/ovf got %0d/%b want 8/0", dcnt[0], dovf[0]);
                end
            end
        end
        n_cmp++;
        if (dcnt[0] !== 4'd8 || dovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow@33: count/ovf got %0d/%b want 8/1", dcnt[0], dovf[0]);
        end
        en = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (dval[0] !== 1'b1 || dout[0] !== 9'(1 + 4 * i)) begin
                n_fail++;
                $display("FAIL drain[%0d]: valid/data got %b/%0d want 1/%0d", i, dval[0], dout[0], 1 + 4 * i);
            end
            tick();
        end
        n_cmp++;
        if (dval[0] !== 1'b0 || dout[0] !== 9'd0 || dovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL after_drain: valid/data/ovf got %b/%0d/%b want 0/0/1", dval[0], dout[0], dovf[0]);
        end
    endtask

    task automatic test_full_pushpop();
        logic [8:0] got [11];
        logic [8:0] want;
        int n = 0;
        do_reset();
        rdy = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 9'(200 + i);
            tick();
        end
        n_cmp++;
        if (dcnt[1] !== 4'd8 || dovf[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL full: count/ovf got %0d/%b want 8/0", dcnt[1], dovf[1]);
        end
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 9'(100 + i);
            got[n] = dval[1] ? dout[1] : 9'h1FF;
            n++;
            tick();
            n_cmp++;
            if (dcnt[1] !== 4'd8 || dovf[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL pushpop[%0d]: count/ovf got %0d/%b want 8/0", i, dcnt[1], dovf[1]);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got[n] = dval[1] ? dout[1] : 9'h1FF;
            n++;
            tick();
        end
        for (int i = 0; i < 11; i++) begin
            want = (i < 8) ? 9'(200 + i) : 9'(100 + i - 8);
            n_cmp++;
            if (got[i] !== want) begin
                n_fail++;
                $display("FAIL pushpop_order[%0d]: got %0d want %0d", i, got[i], want);
            end
        end
        n_cmp++;
        if (dval[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_empty: valid got %b want 0", dval[1]);
        end
    endtask

    task automatic test_in_en_gaps();
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en = pat[i];
            data_in = 9'(10 + i);
            tick();
        end
        en = 1'b0;
        n_cmp++;
        if (dcnt[2] !== 4'd2 || dout[2] !== 9'd10 || dval[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_first: count/valid/data got %0d/%b/%0d want 2/1/10", dcnt[2], dval[2], dout[2]);
        end
        rdy = 1'b1;
        tick();
        n_cmp++;
        if (dval[2] !== 1'b1 || dout[2] !== 9'd13) begin
            n_fail++;
            $display("FAIL gaps_second: valid/data got %b/%0d want 1/13", dval[2], dout[2]);
        end
        tick();
        n_cmp++;
        if (dval[2] !== 1'b0 || dout[2] !== 9'd0) begin
            n_fail++;
            $display("FAIL gaps_empty: valid/data got %b/%0d want 0/0", dval[2], dout[2]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rdy = 1'b0; en = 1'b1;
        for (int d = 1; d <= 18; d++) begin
            data_in = 9'(d);
            tick();
        end
        n_cmp++;
        if (dcnt[0] !== 4'd5) begin
            n_fail++;
            $display("FAIL reset_mid_pre: count got %0d want 5", dcnt[0]);
        end
        reset = 1'b1; rdy = 1'b1; en = 1'b1; data_in = 9'd99;
        tick();
        reset = 1'b0; rdy = 1'b0; en = 1'b0;
        n_cmp++;
        if (dcnt[0] !== 4'd0 || dval[0] !== 1'b0 || dout[0] !== 9'd0 || dovf[0] !== 1'b0 || dovf[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: count/valid/data/ovf0/ovf1 got %0d/%b/%0d/%b/%b want 0/0/0/0/0",
                     dcnt[0], dval[0], dout[0], dovf[0], dovf[1]);
        end
        en = 1'b1; data_in = 9'd7;
        tick();
        en = 1'b0;
        n_cmp++;
        if (dval[0] !== 1'b1 || dout[0] !== 9'd7 || dcnt[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_mid_next: valid/data/count got %b/%0d/%0d want 1/7/1", dval[0], dout[0], dcnt[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rdy = 1'b1; en = 1'b1;
        for (int d = 0; d < 20; d++) begin
            data_in = 9'(d);
            tick();
            n_cmp++;
            if (dval[1] !== 1'b1 || dout[1] !== 9'(d) || dcnt[1] !== 4'd1 || dovf[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap d=%0d: valid/data/count/ovf got %b/%0d/%0d/%b want 1/%0d/1/0",
                         d, dval[1], dout[1], dcnt[1], dovf[1], d);
            end
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if (dval[1] !== 1'b0 || dout[1] !== 9'd0) begin
            n_fail++;
            $display("FAIL wrap_end: valid/data got %b/%0d want 0/0", dval[1], dout[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset   = ($urandom_range(0, 99) == 0);
            en      = ($urandom_range(0, 3) != 0);
            rdy     = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            data_in = 9'($urandom);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dval[k] !== exp_valid(k) || dout[k] !== exp_data(k) ||
                    dcnt[k] !== exp_count(k) || dovf[k] !== movf[k]) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: valid/data/count/ovf got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                             k, c, dval[k], dout[k], dcnt[k], dovf[k],
                             exp_valid(k), exp_data(k), exp_count(k), movf[k]);
                end
            end
        end
        reset = 1'b0; en = 1'b0; rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_decim();
        test_fill_overflow();
        test_full_pushpop();
        test_in_en_gaps();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_out_decim_fifo.md
Name: fir_out_decim_fifo

Overview:
Downstream stage of the FIR filter. Captures the filter's 9-bit output stream, keeps one of every `decim` qualified samples, and buffers the kept samples in a small first-word-fall-through FIFO. A consumer reads the FIFO through a valid/ready handshake. A sticky overflow flag records any kept sample dropped because the FIFO was full.

Parameters:
word_size_out, 9, sample width; matches the FIR output width (2*word_size_in+1).
decim, 4, decimation factor; legal range ≥1; 1 = keep every sample.
depth, 8, FIFO entries; power of 2, ≥2.

Ports:
clock  input  1  single system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
Data_in  input  word_size_out  FIR output sample, unsigned.
in_en  input  1  sample qualifier; 1 = Data_in is a new sample this cycle.
out_data  output  word_size_out  FIFO head; 0 whenever out_valid=0.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts the head this cycle.
count  output  $clog2(depth)+1  current occupancy, 0..depth.
overflow  output  1  sticky; set when a kept sample is dropped.

Behaviour:
- Reset (reset=1 at a clock edge):
  - All of these clear to 0: wr_ptr, rd_ptr, count, decimation counter (dcnt), overflow.
  - out_valid=0 and out_data=0 from the following cycle.
  - Memory contents are not cleared; they are unobservable.
  - Reset mid-operation discards all stored entries and any pop/push in that same cycle.
- Decimation:
  - dcnt counts only cycles with in_en=1, 0..decim-1, then wraps to 0.
  - A sample is "kept" when in_en=1 and dcnt==0. The first qualified sample after reset is always kept.
  - in_en=0 holds dcnt unchanged; gaps in in_en do not affect which samples are kept.
  - decim=1: dcnt stays 0 and every qualified sample is kept.
- Push: a kept sample is written at wr_ptr when not full, or when full with a pop in the same cycle. wr_ptr then increments modulo depth.
- Drop: kept sample while full with no pop in the same cycle:
  - Sample is discarded; wr_ptr and count are unchanged.
  - overflow is set at that edge and stays set until reset.
- Pop: when out_valid=1 and out_ready=1, rd_ptr increments modulo depth.
  - out_ready with out_valid=0 has no effect.
- count update: +1 on push only, −1 on pop only, unchanged on push+pop or on neither.
- Simultaneous push+pop:
  - When empty: push only; no pop is possible.
  - When full: both occur; count stays depth; no overflow.
- Outputs:
  - out_valid = (count≠0), registered-state derived.
  - out_data = mem[rd_ptr] when out_valid, else 0 (FWFT).
- Latency: a sample kept at edge N is visible on out_data with out_valid=1 at cycle N+1 if the FIFO was empty.
- Ordering is strict FIFO, including across pointer wrap-around.
- No arithmetic on data; the width passes through unchanged.

Test Plan:
1. Basic decimation: reset, decim=4, out_ready=1, in_en=1, Data_in=1..12 on consecutive cycles -> out_data 1, 5, 9. Each has out_valid=1 for exactly one cycle, one cycle after its input edge; count never exceeds 1.
2. Fill and overflow: out_ready=0, decim=4, feed 1..33 -> after sample 29, count=8 and overflow=0. Sample 33 is dropped: overflow=1, count=8. Then out_ready=1 drains 1, 5, 9, 13, 17, 21, 25, 29 in order; afterwards out_valid=0, out_data=0, and overflow stays 1.
3. Full with simultaneous push/pop: fill to 8 with decim=1, then out_ready=1 while feeding 100, 101, 102 -> count stays 8 and overflow stays 0. Drain order is the original 8 entries followed by 100, 101, 102.
4. in_en gaps: decim=2, in_en pattern 1,0,1,1,0,1 with Data_in=10,11,12,13,14,15 -> kept samples are 10 and 13 (samples 11 and 14 are ignored because in_en=0).
5. Reset mid-operation: count=5 and dcnt=2, assert reset for one cycle -> next cycle count=0, out_valid=0, out_data=0, overflow=0. The next qualified sample (e.g. 7) is kept and appears with out_valid=1 one cycle later.
6. Wrap-around: decim=1, out_ready=1, stream 0..19 continuously -> out_data reproduces 0..19 in order, one cycle late. Pointers wrap twice with no loss, duplication or overflow.
